regfile_wb_arbiter: RTL and testbench

Shares the register file's single synchronous write port between two writeback requesters: req0 (ALU/execute) and req1 (load/memory). It grants one request per cycle using round-robin order and registers the winning write onto the register-file write port. It also provides rs1/rs2 forwarding for the write in flight. A halt sequence drains the in-flight write, then freezes the port, so the register file is quiescent when the CPU reports halted.

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load writeback
// paths: round-robin grant, one registered write per cycle, forwarding, halt/drain.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_din,
  output logic              halted,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;  // 1 when req1 won the most recent handshake
  logic   grant0, grant1;
  logic   conflict;

  assign conflict = req0_valid & req1_valid;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      RUN: begin
        if (halt_req) begin
          state_next = DRAIN;
        end else if (conflict) begin
          grant0 = last_grant;
          grant1 = ~last_grant;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      DRAIN:   state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Write stage; a reset edge drops whatever was granted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_din     <= '0;
    end else begin
      rf_we <= 1'b0;
      if (grant0) begin
        last_grant <= 1'b0;
        rf_we      <= (req0_rd != '0);
        rf_rd      <= req0_rd;
        rf_din     <= req0_data;
      end else if (grant1) begin
        last_grant <= 1'b1;
        rf_we      <= (req1_rd != '0);
        rf_rd      <= req1_rd;
        rf_din     <= req1_data;
      end
    end
  end

  // Counts contention even when a halt request suppresses the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (state == RUN && conflict && conflict_cnt != {CNT_W{1'b1}}) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign halted     = (state == HALTED);

  assign fwd1_hit = rf_we & (rf_rd == rs1) & (rs1 != '0);
  assign fwd2_hit = rf_we & (rf_rd == rs2) & (rs2 != '0);
  assign fwd_data = rf_din;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_HALT  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_rd = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_rd = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic              halt_req = 1'b0;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_din;
  logic              halted;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .halt_req    (halt_req),
    .rs1         (rs1),
    .rs2         (rs2),
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd_data    (fwd_data),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_din      (rf_din),
    .halted      (halted),
    .conflict_cnt(conflict_cnt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected register-file writes, each tagged with the cycle it must appear in.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    int                due;
  } wr_t;
  wr_t exp_q[$];

  // Reference model state.
  int                phase;
  bit                last_was_req1;
  int                cnt;
  bit                in_flight;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_din;

  // Monitor: every write the DUT presents must match the next expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rf_rd), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_cycle", 64'(cyc), 64'(mon_e.due));
        check("wb_rd", 64'(rf_rd), 64'(mon_e.rd));
        check("wb_data", 64'(rf_din), 64'(mon_e.data));
      end
    end
  end

  task automatic model_reset();
    phase         = P_RUN;
    last_was_req1 = 1'b1;
    cnt           = 0;
    in_flight     = 1'b0;
    m_rd          = '0;
    m_din         = '0;
  endtask

  // Reset is asserted together with a would-be request that must never reach the port.
  task automatic do_reset();
    @(posedge clk); #1;
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_rd    = 5'd9;
    req0_data  = 32'hDEAD_BEEF;
    req1_valid = 1'b0;
    halt_req   = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b0;
    req0_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_rd", 64'(rf_rd), 64'd0);
    check("rst_rf_din", 64'(rf_din), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
  endtask

  task automatic step(input bit v0, input logic [ADDR_W-1:0] rd0, input logic [DATA_W-1:0] d0,
                      input bit v1, input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] d1,
                      input bit halt, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                      output bit g0, output bit g1);
    @(posedge clk); #1;
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    halt_req = halt; rs1 = a1; rs2 = a2;

    // A lone request wins; under contention the side that did not win last time wins.
    g0 = 1'b0;
    g1 = 1'b0;
    if (phase == P_RUN && !halt) begin
      if (v0 && v1) begin
        g0 = last_was_req1;
        g1 = !last_was_req1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end

    @(negedge clk);
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    check("halted", 64'(halted), 64'(phase == P_HALT));
    check("conflict_cnt", 64'(conflict_cnt), 64'(cnt));
    check("rf_we", 64'(rf_we), 64'(in_flight));
    check("rf_rd_hold", 64'(rf_rd), 64'(m_rd));
    check("fwd_data", 64'(fwd_data), 64'(m_din));
    check("fwd1_hit", 64'(fwd1_hit), 64'(in_flight && m_rd == a1 && a1 != 0));
    check("fwd2_hit", 64'(fwd2_hit), 64'(in_flight && m_rd == a2 && a2 != 0));

    if (phase == P_RUN && v0 && v1 && cnt < CNT_MAX) cnt++;
    in_flight = 1'b0;
    if (g0 || g1) begin
      last_was_req1 = g1;
      m_rd          = g0 ? rd0 : rd1;
      m_din         = g0 ? d0 : d1;
      if (m_rd != 0) begin
        in_flight = 1'b1;
        exp_q.push_back('{rd: m_rd, data: m_din, due: cyc + 1});
      end
    end
    if (phase == P_DRAIN)                phase = P_HALT;
    else if (phase == P_RUN && halt)     phase = P_DRAIN;
  endtask

  task automatic idle(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    bit g0, g1;
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, a1, a2, g0, g1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit g0, g1;
    bit p0v, p1v;
    logic [ADDR_W-1:0] p0rd, p1rd;
    logic [DATA_W-1:0] p0d, p1d;
    bit halt;

    model_reset();
    do_reset();

    // Single ALU write.
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    idle('0, '0);

    // Round-robin under constant contention, from a fresh reset.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, '0, '0, g0, g1);
    idle('0, '0);

    // x0 write is accepted but dropped; it still moves the round-robin pointer.
    step(1'b1, 5'd3, 32'h3, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, g0, g1);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, g0, g1);
    step(1'b0, '0, '0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, g0, g1);

    // Forwarding of the in-flight write.
    step(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd7);

    // Halt: the write granted just before the halt still lands, then the port freezes.
    do_reset();
    step(1'b0, '0, '0, 1'b1, 5'd17, 32'd10, 1'b0, 5'd17, '0, g0, g1);
    step(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b1, 5'd17, '0, g0, g1);
    step(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0, g0, g1);

    // Reset out of HALTED, then drive the counter into saturation.
    do_reset();
    for (int i = 0; i < CNT_MAX + 6; i++)
      step(1'b1, 5'd8, 32'(i), 1'b1, 5'd9, 32'(i + 100), 1'b0, 5'd8, 5'd9, g0, g1);
    idle('0, '0);

    // Randomized traffic; requesters hold their request until it is accepted.
    do_reset();
    p0v = 1'b0; p1v = 1'b0;
    p0rd = '0;  p1rd = '0;
    p0d = '0;   p1d = '0;
    for (int i = 0; i < 800; i++) begin
      if (!p0v && $urandom_range(1, 0) == 1) begin
        p0v = 1'b1; p0rd = 5'($urandom_range(7, 0)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(1, 0) == 1) begin
        p1v = 1'b1; p1rd = 5'($urandom_range(7, 0)); p1d = $urandom;
      end
      halt = (phase != P_RUN) || ($urandom_range(39, 0) == 0);
      step(p0v, p0rd, p0d, p1v, p1rd, p1d, halt,
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), g0, g1);
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
      if (phase == P_HALT && $urandom_range(3, 0) == 0) begin
        do_reset();
        p0v = 1'b0;
        p1v = 1'b0;
      end
    end

    idle('0, '0);
    idle('0, '0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
